regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//   Parametrised integer register file with a built-in busy scoreboard for the next-generation
//   pipelined core. Sits inside the core between decode (read/reserve) and writeback.
//   Replaces the flat 32-entry regfile: adds N read ports, write-to-read bypass and per-register
//   busy tracking for multi-cycle producers. Also adds a reset that clears all architectural
//   state, so benches no longer preload zeros hierarchically.
// PARAMETERS
//   XLEN     32  data width in bits
//   NREGS    32  number of architectural registers, >=2, need not be a power of 2
//   AW       5   address width, must be >= $clog2(NREGS)
//   NRD      2   number of read ports, 1..4
//   ZERO_REG 1   1: register 0 is hardwired to zero; 0: register 0 is an ordinary register
//   BYPASS   1   1: same-cycle write data is forwarded to the read ports
// PORTS
//   clk      in   1         rising-edge clock
//   rst      in   1         synchronous reset, active-low
//   rd_addr  in   NRD*AW    read addresses; port i uses bits [i*AW +: AW]
//   rd_data  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN]; combinational
//   rd_busy  out  NRD       1: the addressed register has an outstanding producer
//   wr_en    in   1         writeback strobe
//   wr_addr  in   AW        writeback register
//   wr_data  in   XLEN      writeback data
//   rsv_en   in   1         reserve request: mark rsv_addr busy
//   rsv_addr in   AW        register to reserve
//   rsv_ack  out  1         combinational; 1 when the reservation is accepted this cycle
//   n_busy   out  AW+1      registered count of busy registers
//   dbg_addr in   AW        debug read address, for the bench
//   dbg_data out  XLEN      contents of regs[dbg_addr]; combinational; no bypass applied
// BEHAVIOUR
//   Reset (rst==0 at posedge): all regs cleared to 0, all busy bits cleared, n_busy set to 0.
//     Reset dominates any wr_en/rsv_en in the same cycle.
//     A reset mid-operation drops every outstanding reservation.
//   Write: at posedge with wr_en=1, regs[wr_addr] <= wr_data and busy[wr_addr] <= 0.
//     Latency: one cycle to the array.
//   Read, per port: addr>=NREGS -> 0; ZERO_REG && addr==0 -> 0;
//     BYPASS && wr_en && wr_addr==addr -> wr_data; otherwise regs[addr].
//   rd_busy: 0 for an invalid or zero address.
//     BYPASS=1: busy[addr] & ~(wr_en & wr_addr==addr).
//     BYPASS=0: the registered busy bit.
//   Reserve: rsv_ack = rsv_en & valid addr & ~effective_busy(rsv_addr).
//     effective_busy is defined the same way as rd_busy.
//     When rsv_ack=1, busy[rsv_addr] is set to 1 at the posedge.
//     A reserve of a busy register is rejected (ack=0, no state change); one producer per register.
//   Reserve to register 0 with ZERO_REG=1: rsv_ack=1, no state change.
//   Simultaneous wr and rsv to the same register: the data is written and busy ends at 1
//     (the new producer wins).
//   Invalid address (>=NREGS) on wr or rsv: ignored; rsv_ack=0.
//   Writes to register 0 with ZERO_REG=1 are ignored.
//   n_busy tracks the population of the busy bits: +1 on accepted rsv, -1 on a wr that clears a
//     set bit, net 0 when both hit the same register. n_busy never exceeds NREGS.
// TESTING
//   1. Reset: run 3 cycles with rst=0 after random writes -> every dbg_data=0, n_busy=0,
//      rd_busy=0 on all ports.
//   2. Write then read: wr r5=0xDEADBEEF -> next cycle rd port0 r5 = 0xDEADBEEF.
//      In the same cycle as the write, BYPASS=1 returns 0xDEADBEEF and BYPASS=0 returns the old value.
//   3. Register 0: wr r0=0x1234, then read r0 on all ports -> 0; rsv r0 -> rsv_ack=1, n_busy stays 0.
//   4. Scoreboard: rsv r7 -> ack=1, n_busy=1, rd_busy=1. A second rsv r7 -> ack=0.
//      wr r7=0x55 -> n_busy=0, rd_busy=0, data=0x55.
//   5. Same-cycle wr+rsv to r9 with r9 already busy -> ack=1 (BYPASS=1), r9 data updated,
//      r9 still busy, n_busy unchanged.
//   6. Reserve r1..r31 -> n_busy=31. Then assert rst=0 for 1 cycle -> n_busy=0.
//      Repeat with NREGS=24: rsv r30 -> ack=0; read r30 -> 0.

Source files
------------

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_if
// Description : Bus bundle for the scoreboarded register file. Carries the
//               read ports, writeback, reserve request/ack, busy count and
//               the debug read port.
//               master : decode/writeback side (drives addresses, strobes)
//               slave  : register file (drives data, busy, ack, count)
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
);
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                rsv_ack;
    logic [AW:0]         n_busy;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, dbg_addr,
        input  rd_data, rd_busy, rsv_ack, n_busy, dbg_data
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, dbg_addr,
        output rd_data, rd_busy, rsv_ack, n_busy, dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Parametrised integer register file with NRD combinational
//               read ports, optional write-to-read bypass, optional
//               hardwired-zero register 0 and a per-register busy
//               scoreboard for multi-cycle producers.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous reset, active-low; clears regs, busy bits
//                      and the busy count
//               bus  - regfile_sb_if.slave: rd_addr/rd_data/rd_busy,
//                      wr_en/wr_addr/wr_data, rsv_en/rsv_addr/rsv_ack,
//                      n_busy (registered), dbg_addr/dbg_data (no bypass)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam logic [AW:0] c_nregs = (AW+1)'(NREGS);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_n_busy;

    function automatic logic f_valid(input logic [AW-1:0] a);
        return ({1'b0, a} < c_nregs);
    endfunction

    function automatic logic f_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Out-of-range addresses are steered to index 0 so no array access ever
    // leaves the array; their results are masked off by the validity checks.
    function automatic logic [AW-1:0] f_idx(input logic [AW-1:0] a);
        return f_valid(a) ? a : '0;
    endfunction

    // ---------------------------------------------------------------- write
    logic          w_wr_ok;
    logic [AW-1:0] w_wr_idx;
    logic          w_wr_dec;

    assign w_wr_ok  = bus.wr_en && f_valid(bus.wr_addr) && !f_zero(bus.wr_addr);
    assign w_wr_idx = f_idx(bus.wr_addr);
    // A write retiring an outstanding producer drops the busy population.
    assign w_wr_dec = w_wr_ok && r_busy[w_wr_idx];

    // ------------------------------------------------------------ read ports
    logic [XLEN-1:0] w_rd_data [NRD];
    logic [NRD-1:0]  w_rd_busy;

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic [AW-1:0] w_idx;
        logic          w_ok;
        logic          w_hit;

        assign w_addr = bus.rd_addr[gi*AW +: AW];
        assign w_idx  = f_idx(w_addr);
        assign w_ok   = f_valid(w_addr) && !f_zero(w_addr);
        assign w_hit  = (BYPASS != 0) && w_wr_ok && (bus.wr_addr == w_addr);

        assign w_rd_data[gi] = !w_ok ? '0 : (w_hit ? bus.wr_data : r_regs[w_idx]);
        assign w_rd_busy[gi] = w_ok && r_busy[w_idx] && !w_hit;
    end

    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            bus.rd_data[i*XLEN +: XLEN] = w_rd_data[i];
        end
    end

    assign bus.rd_busy = w_rd_busy;

    // --------------------------------------------------------------- reserve
    logic          w_rsv_ok;
    logic [AW-1:0] w_rsv_idx;
    logic          w_rsv_hit;
    logic          w_rsv_busy;
    logic          w_rsv_set;

    assign w_rsv_idx  = f_idx(bus.rsv_addr);
    assign w_rsv_ok   = f_valid(bus.rsv_addr) && !f_zero(bus.rsv_addr);
    assign w_rsv_hit  = (BYPASS != 0) && w_wr_ok && (bus.wr_addr == bus.rsv_addr);
    assign w_rsv_busy = w_rsv_ok && r_busy[w_rsv_idx] && !w_rsv_hit;

    // Register 0 (when hardwired) is always accepted but never tracked.
    assign bus.rsv_ack = bus.rsv_en && f_valid(bus.rsv_addr) && !w_rsv_busy;
    assign w_rsv_set   = bus.rsv_ack && w_rsv_ok;

    // ----------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy   <= '0;
            r_n_busy <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[w_wr_idx] <= bus.wr_data;
                r_busy[w_wr_idx] <= 1'b0;
            end
            // Placed after the write so a same-register reserve leaves the
            // bit set: the new producer owns the register.
            if (w_rsv_set) begin
                r_busy[w_rsv_idx] <= 1'b1;
            end
            r_n_busy <= r_n_busy + (AW+1)'(w_rsv_set) - (AW+1)'(w_wr_dec);
        end
    end

    assign bus.n_busy   = r_n_busy;
    assign bus.dbg_data = f_valid(bus.dbg_addr) ? r_regs[f_idx(bus.dbg_addr)] : '0;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Directed bench for regfile_sb. Three instances share one
//               stimulus stream: u_dut (defaults), u_nb (BYPASS=0) and
//               u_24 (NREGS=24). Expected values are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0]   ra0, ra1, wr_addr, rsv_addr, dbg_addr;
    logic            wr_en, rsv_en;
    logic [XLEN-1:0] wr_data;

    int n_vec = 0;
    int n_err = 0;

    regfile_sb_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) if_a ();
    regfile_sb_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) if_b ();
    regfile_sb_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) if_c ();

    assign if_a.rd_addr = {ra1, ra0};
    assign if_a.wr_en = wr_en;       assign if_a.wr_addr = wr_addr;
    assign if_a.wr_data = wr_data;   assign if_a.rsv_en = rsv_en;
    assign if_a.rsv_addr = rsv_addr; assign if_a.dbg_addr = dbg_addr;

    assign if_b.rd_addr = {ra1, ra0};
    assign if_b.wr_en = wr_en;       assign if_b.wr_addr = wr_addr;
    assign if_b.wr_data = wr_data;   assign if_b.rsv_en = rsv_en;
    assign if_b.rsv_addr = rsv_addr; assign if_b.dbg_addr = dbg_addr;

    assign if_c.rd_addr = {ra1, ra0};
    assign if_c.wr_en = wr_en;       assign if_c.wr_addr = wr_addr;
    assign if_c.wr_data = wr_data;   assign if_c.rsv_en = rsv_en;
    assign if_c.rsv_addr = rsv_addr; assign if_c.dbg_addr = dbg_addr;

    regfile_sb #(.XLEN(XLEN), .NREGS(32), .AW(AW), .NRD(NRD), .ZERO_REG(1), .BYPASS(1))
        u_dut (.clk(clk), .rst(rst), .bus(if_a));
    regfile_sb #(.XLEN(XLEN), .NREGS(32), .AW(AW), .NRD(NRD), .ZERO_REG(1), .BYPASS(0))
        u_nb  (.clk(clk), .rst(rst), .bus(if_b));
    regfile_sb #(.XLEN(XLEN), .NREGS(24), .AW(AW), .NRD(NRD), .ZERO_REG(1), .BYPASS(1))
        u_24  (.clk(clk), .rst(rst), .bus(if_c));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b0;
        ra0 = '0; ra1 = '0; wr_addr = '0; rsv_addr = '0; dbg_addr = '0;
        wr_en = 1'b0; rsv_en = 1'b0; wr_data = '0;
        tick(); tick();
        check("init_nbusy", 64'(if_a.n_busy), 64'd0);
        rst = 1'b1;

        // ---- reset after activity
        wr_en = 1'b1;
        wr_addr = 5'd3;  wr_data = 32'h1111_1111; tick();
        wr_addr = 5'd5;  wr_data = 32'h2222_2222; tick();
        wr_addr = 5'd31; wr_data = 32'h3333_3333; tick();
        wr_en = 1'b0;
        rsv_en = 1'b1; rsv_addr = 5'd10; tick();
        rsv_en = 1'b0;
        dbg_addr = 5'd31; settle();
        check("pre_rst_nbusy", 64'(if_a.n_busy), 64'd1);
        check("pre_rst_dbg31", 64'(if_a.dbg_data), 64'h3333_3333);
        rst = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
            dbg_addr = AW'(a);
            settle();
            check("rst_dbg", 64'(if_a.dbg_data), 64'd0);
        end
        check("rst_nbusy_a", 64'(if_a.n_busy), 64'd0);
        check("rst_nbusy_b", 64'(if_b.n_busy), 64'd0);
        check("rst_nbusy_c", 64'(if_c.n_busy), 64'd0);
        ra0 = 5'd10; ra1 = 5'd5; settle();
        check("rst_rd_busy", 64'(if_a.rd_busy), 64'd0);
        check("rst_rd_data", 64'(if_a.rd_data), 64'd0);

        // ---- write then read, bypass vs no bypass
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; ra0 = 5'd5; settle();
        check("byp_same_cycle", 64'(if_a.rd_data[31:0]), 64'hDEAD_BEEF);
        check("nobyp_same_cycle", 64'(if_b.rd_data[31:0]), 64'd0);
        tick();
        wr_en = 1'b0; settle();
        check("rd_after_wr_a", 64'(if_a.rd_data[31:0]), 64'hDEAD_BEEF);
        check("rd_after_wr_b", 64'(if_b.rd_data[31:0]), 64'hDEAD_BEEF);

        // ---- register 0
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234; ra0 = 5'd0; ra1 = 5'd0; settle();
        check("r0_byp", 64'(if_a.rd_data), 64'd0);
        tick();
        wr_en = 1'b0; dbg_addr = 5'd0; settle();
        check("r0_rd", 64'(if_a.rd_data), 64'd0);
        check("r0_dbg", 64'(if_a.dbg_data), 64'd0);
        rsv_en = 1'b1; rsv_addr = 5'd0; settle();
        check("r0_rsv_ack", 64'(if_a.rsv_ack), 64'd1);
        tick();
        rsv_en = 1'b0; settle();
        check("r0_nbusy", 64'(if_a.n_busy), 64'd0);

        // ---- scoreboard basics on r7
        rsv_en = 1'b1; rsv_addr = 5'd7; settle();
        check("r7_rsv_ack", 64'(if_a.rsv_ack), 64'd1);
        tick();
        ra1 = 5'd7; settle();
        check("r7_rsv2_ack", 64'(if_a.rsv_ack), 64'd0);
        check("r7_rd_busy", 64'(if_a.rd_busy[1]), 64'd1);
        check("r7_nbusy", 64'(if_a.n_busy), 64'd1);
        tick();
        rsv_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55; settle();
        check("r7_busy_byp", 64'(if_a.rd_busy[1]), 64'd0);
        check("r7_busy_nobyp", 64'(if_b.rd_busy[1]), 64'd1);
        tick();
        wr_en = 1'b0; settle();
        check("r7_nbusy_done", 64'(if_a.n_busy), 64'd0);
        check("r7_busy_done", 64'(if_a.rd_busy[1]), 64'd0);
        check("r7_data", 64'(if_a.rd_data[63:32]), 64'h55);

        // ---- same-cycle write + reserve on busy r9
        rsv_en = 1'b1; rsv_addr = 5'd9; tick();
        rsv_en = 1'b0; settle();
        check("r9_nbusy_a", 64'(if_a.n_busy), 64'd1);
        check("r9_nbusy_b", 64'(if_b.n_busy), 64'd1);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFE_F00D;
        rsv_en = 1'b1; rsv_addr = 5'd9; settle();
        check("r9_ack_byp", 64'(if_a.rsv_ack), 64'd1);
        check("r9_ack_nobyp", 64'(if_b.rsv_ack), 64'd0);
        tick();
        wr_en = 1'b0; rsv_en = 1'b0; dbg_addr = 5'd9; ra0 = 5'd9; settle();
        check("r9_dbg_a", 64'(if_a.dbg_data), 64'hCAFE_F00D);
        check("r9_dbg_b", 64'(if_b.dbg_data), 64'hCAFE_F00D);
        check("r9_still_busy", 64'(if_a.rd_busy[0]), 64'd1);
        check("r9_nbusy_same", 64'(if_a.n_busy), 64'd1);
        check("r9_nbusy_nobyp", 64'(if_b.n_busy), 64'd0);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'd0; tick();
        wr_en = 1'b0; settle();
        check("r9_cleared", 64'(if_a.n_busy), 64'd0);

        // ---- fill scoreboard, invalid addresses, reset drops all
        for (int i = 1; i < 32; i++) begin
            rsv_en = 1'b1; rsv_addr = AW'(i); settle();
            if (i == 30) begin
                check("r30_ack_24", 64'(if_c.rsv_ack), 64'd0);
                check("r30_ack_32", 64'(if_a.rsv_ack), 64'd1);
            end
            tick();
        end
        rsv_en = 1'b0; settle();
        check("full_nbusy_a", 64'(if_a.n_busy), 64'd31);
        check("full_nbusy_b", 64'(if_b.n_busy), 64'd31);
        check("full_nbusy_c", 64'(if_c.n_busy), 64'd23);
        rsv_en = 1'b1; rsv_addr = 5'd5; settle();
        check("r5_rsv_busy", 64'(if_a.rsv_ack), 64'd0);
        rsv_en = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd30; wr_data = 32'h0000_ABCD; ra0 = 5'd30; settle();
        check("r30_rd_24", 64'(if_c.rd_data[31:0]), 64'd0);
        check("r30_busy_24", 64'(if_c.rd_busy[0]), 64'd0);
        check("r30_byp_32", 64'(if_a.rd_data[31:0]), 64'h0000_ABCD);
        rst = 1'b0; tick();
        rst = 1'b1; wr_en = 1'b0; dbg_addr = 5'd30; settle();
        check("rst_nbusy_full_a", 64'(if_a.n_busy), 64'd0);
        check("rst_nbusy_full_c", 64'(if_c.n_busy), 64'd0);
        check("rst_wins_wr", 64'(if_a.dbg_data), 64'd0);
        check("r30_dbg_24", 64'(if_c.dbg_data), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
